// File: rtl/therm_uart_rx_if.sv
// rtl/therm_uart_rx_if.sv - receive-side result bundle of the thermometer UART decoder
interface therm_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic [7:0] avg_data;
  logic       avg_valid;

  modport master (
    output rx_data, rx_valid, frame_err, rx_busy, avg_data, avg_valid
  );

  modport slave (
    input rx_data, rx_valid, frame_err, rx_busy, avg_data, avg_valid
  );
endinterface

// File: rtl/therm_uart_rx.sv
// rtl/therm_uart_rx.sv - 8N1 receiver for the thermometer tx line with a running-average readout
module therm_uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int AVG_LOG2     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx,
  therm_uart_rx_if.master  rx_out
);

  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 8 + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [FW-1:0] F_FULL = FW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          en_q, en_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [7:0]    hist_q [DEPTH];
  logic [7:0]    hist_d [DEPTH];
  logic [7:0]    avg_data_q, avg_data_d;
  logic          avg_valid_q, avg_valid_d;

  always_comb begin
    state_d     = state_q;
    sync1_d     = rx;
    sync2_d     = sync1_q;
    en_d        = en;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    sum_d       = sum_q;
    fill_d      = fill_q;
    hist_d      = hist_q;
    avg_data_d  = avg_data_q;
    avg_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d   = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          if (sync2_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Averager runs one cycle behind the byte so it always sees the registered rx_data.
    if (rx_valid_q) begin
      sum_d = sum_q + SW'(rx_data_q) - SW'(hist_q[DEPTH-1]);
      for (int i = DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = rx_data_q;
      if (fill_q != F_FULL) fill_d = fill_q + 1'b1;
      if (fill_d == F_FULL) begin
        avg_valid_d = 1'b1;
        avg_data_d  = 8'(sum_d >> AVG_LOG2);
      end
    end

    // A line that was ignored while disabled may be mid-frame; resync via BREAK.
    if (en && !en_q) state_d = S_BREAK;

    if (!en) begin
      state_d     = S_IDLE;
      timer_d     = '0;
      bit_idx_d   = '0;
      shift_d     = '0;
      rx_data_d   = '0;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      sum_d       = '0;
      fill_d      = '0;
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      avg_data_d  = '0;
      avg_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      en_q        <= 1'b1;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      fill_q      <= '0;
      hist_q      <= '{default: '0};
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      en_q        <= en_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      hist_q      <= hist_d;
      avg_data_q  <= avg_data_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign rx_out.rx_data   = rx_data_q;
  assign rx_out.rx_valid  = rx_valid_q;
  assign rx_out.frame_err = frame_err_q;
  assign rx_out.rx_busy   = busy_q;
  assign rx_out.avg_data  = avg_data_q;
  assign rx_out.avg_valid = avg_valid_q;

endmodule

// File: tb/tb_therm_uart_rx.sv
// tb/tb_therm_uart_rx.sv - directed bench for therm_uart_rx with CLKS_PER_BIT=16, AVG_LOG2=2
module tb_therm_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  logic rx  = 1'b1;

  always #5 clk = ~clk;

  therm_uart_rx_if bus ();

  therm_uart_rx #(.CLKS_PER_BIT(16), .AVG_LOG2(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rx     (rx),
    .rx_out (bus.master)
  );

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_ferr = 0, n_avg = 0, n_both = 0, n_busyfall = 0;
  logic [7:0] last_rx = 8'h00, last_avg = 8'h00;
  logic prev_busy = 1'b0;
  int v0, f0, a0;

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid++;
      last_rx = bus.rx_data;
      if (prev_busy && !bus.rx_busy) n_busyfall++;
    end
    if (bus.frame_err) n_ferr++;
    if (bus.avg_valid) begin
      n_avg++;
      last_avg = bus.avg_data;
    end
    if (bus.rx_valid && bus.frame_err) n_both++;
    prev_busy = bus.rx_busy;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level so a forced-low stop can be extended.
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(16);
    end
    rx = stop;
    wait_clks(16);
  endtask

  initial begin
    wait_clks(3);
    chk("reset_rx_data", bus.rx_data, 8'h00);
    chk("reset_rx_valid", bus.rx_valid, 0);
    chk("reset_frame_err", bus.frame_err, 0);
    chk("reset_rx_busy", bus.rx_busy, 0);
    chk("reset_avg_data", bus.avg_data, 8'h00);
    chk("reset_avg_valid", bus.avg_valid, 0);
    rst = 1'b1;
    wait_clks(3);

    v0 = n_valid;
    send(8'hA5, 1'b1);
    wait_clks(4);
    chk("t1_valid_count", n_valid - v0, 1);
    chk("t1_data", last_rx, 8'hA5);
    chk("t1_no_ferr", n_ferr, 0);
    chk("t1_busy_falls_with_valid", n_busyfall, 1);

    rst = 1'b0;
    wait_clks(2);
    chk("t2_rst_clears_data", bus.rx_data, 8'h00);
    rst = 1'b1;
    wait_clks(2);

    v0 = n_valid;
    a0 = n_avg;
    send(8'h10, 1'b1);
    send(8'h20, 1'b1);
    send(8'h30, 1'b1);
    wait_clks(4);
    chk("t2_no_avg_before_full", n_avg - a0, 0);
    send(8'h40, 1'b1);
    wait_clks(4);
    chk("t2_valid_count", n_valid - v0, 4);
    chk("t2_avg_count", n_avg - a0, 1);
    chk("t2_avg_data", last_avg, 8'h28);
    send(8'h80, 1'b1);
    wait_clks(4);
    chk("t2_avg_count2", n_avg - a0, 2);
    chk("t2_avg_data2", last_avg, 8'h44);

    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    wait_clks(6);
    rx = 1'b1;
    wait_clks(20);
    chk("t3_glitch_no_valid", n_valid - v0, 0);
    chk("t3_glitch_no_ferr", n_ferr - f0, 0);
    chk("t3_glitch_idle", bus.rx_busy, 0);

    a0 = n_avg;
    send(8'h55, 1'b0);
    wait_clks(40);
    chk("t4_ferr_count", n_ferr - f0, 1);
    chk("t4_no_valid", n_valid - v0, 0);
    chk("t4_data_kept", bus.rx_data, 8'h80);
    chk("t4_busy_in_break", bus.rx_busy, 1);
    chk("t4_avg_untouched", n_avg - a0, 0);
    rx = 1'b1;
    wait_clks(5);
    chk("t4_idle_after_high", bus.rx_busy, 0);
    send(8'h33, 1'b1);
    wait_clks(4);
    chk("t4_next_byte", bus.rx_data, 8'h33);
    chk("t4_avg_count", n_avg - a0, 1);
    chk("t4_avg_data", last_avg, 8'h48);

    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    wait_clks(16);
    rx = 1'b1;
    wait_clks(40);
    en = 1'b0;
    wait_clks(3);
    chk("t5_en_busy_low", bus.rx_busy, 0);
    chk("t5_en_data_zero", bus.rx_data, 8'h00);
    chk("t5_en_avg_zero", bus.avg_data, 8'h00);
    wait_clks(100);
    en = 1'b1;
    wait_clks(5);
    chk("t5_no_valid", n_valid - v0, 0);
    chk("t5_no_ferr", n_ferr - f0, 0);
    a0 = n_avg;
    send(8'h08, 1'b1);
    send(8'h08, 1'b1);
    send(8'h08, 1'b1);
    wait_clks(4);
    chk("t5_fill_cleared", n_avg - a0, 0);
    send(8'h08, 1'b1);
    wait_clks(4);
    chk("t5_avg_count", n_avg - a0, 1);
    chk("t5_avg_data", last_avg, 8'h08);

    v0 = n_valid;
    rx = 1'b0;
    wait_clks(60);
    rst = 1'b0;
    wait_clks(2);
    chk("t5_rst_busy_low", bus.rx_busy, 0);
    rst = 1'b1;
    rx = 1'b1;
    wait_clks(200);
    chk("t5_rst_no_valid", n_valid - v0, 0);

    a0 = n_avg;
    send(8'hFF, 1'b1);
    wait_clks(4);
    chk("t6_ff", bus.rx_data, 8'hFF);
    send(8'h00, 1'b1);
    wait_clks(4);
    chk("t6_00", bus.rx_data, 8'h00);
    chk("t6_valid_count", n_valid - v0, 2);
    chk("t6_no_avg_after_rst", n_avg - a0, 0);
    chk("never_valid_and_ferr", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
